regfile_mp: RTL and testbench

Parametrised multi-port register file for the CPU datapath: NUM_RD asynchronous read ports, NUM_WR synchronous write ports on the rising CLK edge, and a hardwired-zero register 0. It adds a per-register pending scoreboard for in-flight results and a hardware clear sweep after reset, so it can map onto RAM-style storage. It sits between decode (read addresses, issue marking) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 67 ++++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default widths for the multi-port register file
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-result scoreboard and Busy lookup; REGFILE_BYPASS_EN enables write-cycle Busy masking
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [ADDR_W-1:0] ra [NUM_RD];

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wa
    assign wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_ra
    assign ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
  end

  // Issue is applied after the write clears so the newer instruction keeps the bit.
  always_comb begin
    pending_nxt = pending;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && wa[j] != '0) pending_nxt[wa[j]] = 1'b0;
    end
    if (issue_en && issue_addr != '0) pending_nxt[issue_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (ready) begin
      pending <= pending_nxt;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic b;
      b = pending[ra[i]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wa[j] == ra[i] && ra[i] != '0 &&
            !(issue_en && issue_addr == ra[i])) b = 1'b0;
      end
`endif
      busy[i] = ready & b;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with post-reset clear sweep; REGFILE_BYPASS_EN enables write-to-read bypass
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     CLK,
  input  logic                     Reset,
  output logic                     Ready,
  input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]        Busy,
  input  logic [NUM_WR-1:0]        WrEn,
  input  logic [NUM_WR*ADDR_W-1:0] WrAddr,
  input  logic [NUM_WR*DATA_W-1:0] WrData,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueAddr,
  output logic                     WrConflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [NUM_WR-1:0] wr_ok;
  logic              conflict;

  assign Ready = (state == RF_RUN);

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wa[j]    = WrAddr[j*ADDR_W +: ADDR_W];
    assign wd[j]    = WrData[j*DATA_W +: DATA_W];
    assign wr_ok[j] = Ready && WrEn[j] && wa[j] != '0;
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign ra[i] = RdAddr[i*ADDR_W +: ADDR_W];
  end

  always_comb begin
    conflict = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (wr_ok[j] && wr_ok[k] && wa[j] == wa[k]) conflict = 1'b1;
      end
    end
  end

  // Register 0 is never stored to, so the sweep starts at 1 and ends on DEPTH-1.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= RF_CLEAR;
      clr_ptr    <= ADDR_W'(1);
      WrConflict <= 1'b0;
    end else begin
      WrConflict <= conflict;
      if (state == RF_CLEAR) begin
        clr_ptr <= clr_ptr + ADDR_W'(1);
        if (clr_ptr == ADDR_W'(DEPTH - 1)) state <= RF_RUN;
      end
    end
  end

  // Ascending port order lets the higher index win a same-address collision.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (state == RF_CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j]) mem[wa[j]] <= wd[j];
        end
      end
    end
  end

  always_comb begin
    RdData = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [DATA_W-1:0] val;
      val = (ra[i] == '0) ? '0 : mem[ra[i]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (WrEn[j] && wa[j] == ra[i] && ra[i] != '0) val = wd[j];
      end
`endif
      RdData[i*DATA_W +: DATA_W] = Ready ? val : '0;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (CLK),
    .reset      (Reset),
    .ready      (Ready),
    .wr_en      (WrEn),
    .wr_addr    (WrAddr),
    .issue_en   (IssueEn),
    .issue_addr (IssueAddr),
    .rd_addr    (RdAddr),
    .busy       (Busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             Ready;
  logic [NR*AW-1:0] RdAddr;
  logic [NR*DW-1:0] RdData;
  logic [NR-1:0]    Busy;
  logic [NW-1:0]    WrEn;
  logic [NW*AW-1:0] WrAddr;
  logic [NW*DW-1:0] WrData;
  logic             IssueEn;
  logic [AW-1:0]    IssueAddr;
  logic             WrConflict;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 CLK = ~CLK;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Ready      (Ready),
    .RdAddr     (RdAddr),
    .RdData     (RdData),
    .Busy       (Busy),
    .WrEn       (WrEn),
    .WrAddr     (WrAddr),
    .WrData     (WrData),
    .IssueEn    (IssueEn),
    .IssueAddr  (IssueAddr),
    .WrConflict (WrConflict)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!Ready && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    Reset = 1'b1; RdAddr = '0; WrEn = '0; WrAddr = '0; WrData = '0;
    IssueEn = 1'b0; IssueAddr = '0;
    tick();
    chk("rst_ready", Ready, 0);
    chk("rst_conflict", WrConflict, 0);
    chk("rst_rd0", RdData[31:0], 0);
    chk("rst_rd1", RdData[63:32], 0);
    chk("rst_busy", Busy, 0);
    tick();

    // Full clear sweep
    Reset = 1'b0;
    wait_ready(n);
    chk("sweep_edges", n, 31);
    chk("sweep_ready", Ready, 1);
    RdAddr = {5'd31, 5'd5};
    #1;
    chk("swept_rd0", RdData[31:0], 0);
    chk("swept_rd1", RdData[63:32], 0);

    // Reset pulse in the middle of the sweep
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (10) tick();
    chk("mid_ready_low", Ready, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    wait_ready(n);
    chk("mid_sweep_edges", n, 31);

    // Basic write/read
    WrEn = 2'b01; WrAddr = {5'd0, 5'd5}; WrData = {32'h0, 32'hDEADBEEF}; RdAddr = {5'd0, 5'd5};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wr5_same_cycle", RdData[31:0], 32'hDEADBEEF);
`else
    chk("wr5_same_cycle", RdData[31:0], 0);
`endif
    tick();
    WrEn = '0;
    #1;
    chk("wr5_next", RdData[31:0], 32'hDEADBEEF);

    // Write to register 0 is dropped
    WrEn = 2'b01; WrAddr = '0; WrData = {32'h0, 32'h1234}; RdAddr = '0;
    tick();
    WrEn = '0;
    #1;
    chk("wr0_rd", RdData[31:0], 0);
    chk("wr0_noconflict", WrConflict, 0);

    // Collision on register 7
    WrEn = 2'b11; WrAddr = {5'd7, 5'd7}; WrData = {32'h22, 32'h11}; RdAddr = {5'd0, 5'd7};
    tick();
    WrEn = '0;
    #1;
    chk("coll_pulse", WrConflict, 1);
    chk("coll_winner", RdData[31:0], 32'h22);
    tick();
    chk("coll_pulse_end", WrConflict, 0);

    // Scoreboard
    IssueEn = 1'b1; IssueAddr = 5'd9; RdAddr = {5'd9, 5'd0};
    #1;
    chk("issue_busy_pre", Busy[1], 0);
    tick();
    IssueEn = 1'b0;
    #1;
    chk("issue_busy", Busy[1], 1);
    IssueEn = 1'b1; IssueAddr = 5'd9; WrEn = 2'b01; WrAddr = {5'd0, 5'd9}; WrData = {32'h0, 32'h99};
    #1;
    chk("issue_wr_same_cycle", Busy[1], 1);
    tick();
    IssueEn = 1'b0; WrEn = '0;
    #1;
    chk("issue_wr_busy", Busy[1], 1);
    chk("issue_wr_data", RdData[63:32], 32'h99);
    WrEn = 2'b01; WrAddr = {5'd0, 5'd9}; WrData = {32'h0, 32'hAA};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wr9_busy_same", Busy[1], 0);
`else
    chk("wr9_busy_same", Busy[1], 1);
`endif
    tick();
    WrEn = '0;
    #1;
    chk("wr9_busy_clr", Busy[1], 0);
    chk("wr9_data", RdData[63:32], 32'hAA);

    // Issue to register 0 never marks pending
    IssueEn = 1'b1; IssueAddr = 5'd0; RdAddr = '0;
    tick();
    IssueEn = 1'b0;
    #1;
    chk("issue0_busy", Busy, 0);

    // Same-cycle read of a register being written
    WrEn = 2'b01; WrAddr = {5'd0, 5'd3}; WrData = {32'h0, 32'hCAFE}; RdAddr = {5'd3, 5'd0};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", RdData[63:32], 32'hCAFE);
`else
    chk("byp_same", RdData[63:32], 0);
`endif
    tick();
    WrEn = '0;
    #1;
    chk("byp_next", RdData[63:32], 32'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
